countdown_ctrl: RTL
===================

// Module: countdown_ctrl
// PURPOSE
//  Sequencing FSM for the countdown timer. Holds the remaining time as 4 BCD digits and decrements once per
//  1 Hz tick from the prescaler CEO. Reacts to start/pause and load pulses, flags expiry, and drives the
//  BCD digits and digit-enable mask consumed by the 7-segment display driver.
// PARAMETERS
//  DEFAULT_BCD  16'h0060  preset and reload value after reset; four BCD digits, MS digit in [15:12]
// PORTS
//  CLK        in   1   system clock
//  CLR        in   1   synchronous reset, active-high
//  TICK       in   1   1-cycle 1 Hz enable from the prescaler CEO
//  START_STOP in   1   1-cycle pulse from a debounced button: start, pause or resume, or acknowledge
//  LOAD       in   1   1-cycle pulse: capture LOAD_BCD as the new preset
//  LOAD_BCD   in   16  preset value; any nibble > 9 is clamped to 9 on capture
//  BCD        out  16  remaining time, registered
//  DIG_EN     out  4   per-digit enable, bit0 = LS digit, 1 = lit
//  RUNNING    out  1   1 while in RUN
//  DONE       out  1   1 while in DONE
// BEHAVIOUR
//  - One clock; CLR is synchronous and active-high. All outputs are registered and update at the CLK edge.
//  - Reset values: state=IDLE; BCD=preset=DEFAULT_BCD; RUNNING=0; DONE=0; DIG_EN follows blanking of BCD.
//  - CLR asserted mid-count: same reset values; counting is abandoned.
//  - States: IDLE, RUN, PAUSE, DONE. Priority in every state: CLR > LOAD > START_STOP > TICK.
//  - LOAD, any state: preset<=clamp(LOAD_BCD); BCD<=clamp(LOAD_BCD); state->IDLE. A same-cycle TICK is dropped.
//  - IDLE:  START_STOP and BCD!=0 -> RUN.
//           START_STOP and BCD==0 -> stays in IDLE.
//           TICK is ignored.
//  - RUN:   TICK decrements BCD by 1 with BCD borrow (e.g. 0100 -> 0099, 1000 -> 0999).
//           When the decrement takes BCD from 0001 to 0000, state->DONE on that same edge.
//           START_STOP -> PAUSE. A same-cycle TICK is dropped; there is no decrement.
//  - PAUSE: START_STOP -> RUN. A same-cycle TICK is dropped. Otherwise TICK is ignored; BCD is frozen.
//  - DONE:  BCD holds 0000. START_STOP (acknowledge) -> IDLE with BCD<=preset.
//  - Latency: each TICK that decrements appears on BCD 1 cycle later. State changes are visible next cycle.
//  - BCD never wraps below 0000, and a TICK is never applied at 0000.
//  - DIG_EN, leading-zero blanking: the LS digit is always lit; a higher digit is lit iff it or any digit
//    above it is non-zero. Example: 0060 -> 4'b0011.
// CONFIGURATION
//  - COUNTDOWN_ALARM_BLINK_EN defined: in DONE, DIG_EN toggles between 4'b1111 and 4'b0000 on each TICK.
//    It is 4'b1111 on DONE entry and reverts to blanking rules on exit.
//  - COUNTDOWN_ALARM_BLINK_EN undefined: in DONE, DIG_EN is held at 4'b1111; TICK has no effect in DONE.
// STRUCTURE
//  - Package countdown_pkg holds:
//    - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
//    - BCD_DIGITS=4;
//    - nibble clamp function;
//    - leading-zero mask function.
//  - Sub-module bcd_down_cnt4 provides the 4-digit BCD decrement with borrow chain, load and hold.
//    Its outputs are the next value and ONE flag (value==0001).
//  - The FSM and output registers live in countdown_ctrl.
// TESTING
//  1. CLR=1 for 2 cycles, then idle -> BCD=0060, DIG_EN=0011, RUNNING=0, DONE=0.
//  2. LOAD with 16'h0003, then START_STOP, then 3 TICKs:
//     -> BCD steps 0003,0002,0001,0000; DONE=1 the cycle after the 3rd TICK; RUNNING=0.
//  3. LOAD 16'h1000, START_STOP, 1 TICK -> BCD=0999, DIG_EN=0111.
//     Then LOAD 16'hFA5C -> BCD=9959 (nibbles > 9 clamped), state IDLE.
//  4. In RUN, START_STOP and TICK in the same cycle -> PAUSE, BCD unchanged.
//     Then 5 TICKs -> BCD unchanged. Then START_STOP -> RUN resumes from the held value.
//  5. In DONE, START_STOP -> IDLE, BCD=last preset.
//     Also: START_STOP in IDLE with BCD=0000 (via LOAD 0) -> stays IDLE, RUNNING=0.
//  6. CLR mid-RUN at BCD=0042 -> next cycle BCD=0060, IDLE.
//     Blink build: in DONE, 3 TICKs -> DIG_EN 0000,1111,0000.
//     Non-blink build: DIG_EN stays 1111.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown timer: state encoding, digit count,
// nibble clamping and leading-zero blanking mask.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  function automatic logic [3:0] clamp_nib(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[4*i +: 4] = clamp_nib(v[4*i +: 4]);
    end
    return r;
  endfunction

  // LS digit always lit; a higher digit is lit once any digit at or above it is non-zero.
  function automatic logic [BCD_DIGITS-1:0] lz_mask(input logic [BCD_W-1:0] v);
    logic [BCD_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      seen = seen | (v[4*i +: 4] != 4'd0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/bcd_down_cnt4.sv
// Purpose: next-value logic for a 4-digit BCD down counter (load > decrement > hold).
// Latency: combinational; the caller registers nxt. Backpressure: none, decrement at 0000 is suppressed.
module bcd_down_cnt4
  import countdown_pkg::*;
(
  input  logic [BCD_W-1:0] cur,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] nxt,
  output logic             one
);

  logic [BCD_W-1:0] dec_val;
  logic             borrow;
  logic             is_zero;

  // Ripple borrow from the LS digit: a zero digit wraps to 9 and passes the borrow upward.
  always_comb begin
    dec_val = cur;
    borrow  = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (borrow) begin
        if (cur[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = cur[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  assign is_zero = (cur == '0);
  assign one     = (cur == {{(BCD_W-4){1'b0}}, 4'd1});

  always_comb begin
    nxt = cur;
    if (load) begin
      nxt = load_val;
    end else if (dec && !is_zero) begin
      nxt = dec_val;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Purpose: countdown sequencing FSM (IDLE/RUN/PAUSE/DONE) with BCD time and digit blanking; COUNTDOWN_ALARM_BLINK_EN blinks DIG_EN in DONE.
// Latency: all outputs registered, one cycle after the causing TICK/pulse. Backpressure: none, pulses act on the cycle they arrive.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter logic [15:0] DEFAULT_BCD = 16'h0060
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        TICK,
  input  logic        START_STOP,
  input  logic        LOAD,
  input  logic [15:0] LOAD_BCD,
  output logic [15:0] BCD,
  output logic [3:0]  DIG_EN,
  output logic        RUNNING,
  output logic        DONE
);

  state_t           state_q, state_d;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] preset_q, preset_d;
  logic [3:0]       dig_en_q, dig_en_d;
  logic             running_q, done_q;

  logic             cnt_load;
  logic [BCD_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [BCD_W-1:0] cnt_nxt;
  logic             cnt_one;
  logic [BCD_W-1:0] load_clamped;

  assign load_clamped = clamp_bcd(LOAD_BCD);

  bcd_down_cnt4 u_cnt (
    .cur      (bcd_q),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .nxt      (cnt_nxt),
    .one      (cnt_one)
  );

  // LOAD outranks START_STOP, which outranks TICK; a lower-priority pulse in the same cycle is dropped.
  always_comb begin
    state_d      = state_q;
    preset_d     = preset_q;
    cnt_load     = 1'b0;
    cnt_load_val = preset_q;
    cnt_dec      = 1'b0;
    if (LOAD) begin
      preset_d     = load_clamped;
      cnt_load     = 1'b1;
      cnt_load_val = load_clamped;
      state_d      = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (START_STOP && (bcd_q != '0)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (START_STOP) begin
            state_d = ST_PAUSE;
          end else if (TICK) begin
            cnt_dec = 1'b1;
            if (cnt_one) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (START_STOP) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (START_STOP) begin
            cnt_load = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // DONE forces every digit lit; otherwise blanking follows the value being registered.
  always_comb begin
    dig_en_d = lz_mask(cnt_nxt);
    if (state_d == ST_DONE) begin
`ifdef COUNTDOWN_ALARM_BLINK_EN
      if (state_q != ST_DONE) begin
        dig_en_d = 4'b1111;
      end else if (TICK) begin
        dig_en_d = ~dig_en_q;
      end else begin
        dig_en_d = dig_en_q;
      end
`else
      dig_en_d = 4'b1111;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      bcd_q     <= DEFAULT_BCD;
      preset_q  <= DEFAULT_BCD;
      dig_en_q  <= lz_mask(DEFAULT_BCD);
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= cnt_nxt;
      preset_q  <= preset_d;
      dig_en_q  <= dig_en_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign BCD     = bcd_q;
  assign DIG_EN  = dig_en_q;
  assign RUNNING = running_q;
  assign DONE    = done_q;

endmodule
